// File: rtl/bit_fifo.sv
// Width-converting bit FIFO: packs IWIDTH-bit words into OWIDTH-bit words, oldest bit in MSB.
// Optional BIT_FIFO_FLUSH_EN adds a flush input that emits held residue left-justified.
module bit_fifo #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [IWIDTH-1:0] in,
  input  logic              in_valid,
`ifdef BIT_FIFO_FLUSH_EN
  input  logic              flush,
`endif
  output logic [OWIDTH-1:0] out,
  output logic              out_valid
);

  localparam int BW = IWIDTH + OWIDTH - 1;
  localparam int CW = $clog2(BW + 1);

  generate
    if (IWIDTH < 1 || OWIDTH < 1 || IWIDTH > OWIDTH) begin : g_bad_params
      $error("bit_fifo: need 1 <= IWIDTH <= OWIDTH (IWIDTH=%0d OWIDTH=%0d)", IWIDTH, OWIDTH);
    end
  endgenerate

  // Buffer is left-justified: held bits occupy the top count_q positions, the rest stay zero.
  logic [BW-1:0]     buf_q, buf_d;
  logic [CW-1:0]     count_q, count_d;
  logic [OWIDTH-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic [BW-1:0]     in_ext;
  logic [BW-1:0]     merged;
  logic [CW-1:0]     next_count;

  always_comb begin
    accept      = en & in_valid;
    in_ext      = BW'(in) << (BW - IWIDTH);
    merged      = accept ? (buf_q | (in_ext >> count_q)) : buf_q;
    next_count  = count_q + (accept ? CW'(IWIDTH) : '0);

    count_d     = next_count;
    buf_d       = merged;
    out_d       = out_q;
    out_valid_d = 1'b0;

    if (next_count >= CW'(OWIDTH)) begin
      out_d       = merged[BW-1 -: OWIDTH];
      out_valid_d = 1'b1;
      count_d     = next_count - CW'(OWIDTH);
      buf_d       = merged << OWIDTH;
    end
`ifdef BIT_FIFO_FLUSH_EN
    // Zero-fill below the residue makes the top slice already zero-padded.
    else if (flush && next_count != '0) begin
      out_d       = merged[BW-1 -: OWIDTH];
      out_valid_d = 1'b1;
      count_d     = '0;
      buf_d       = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bit_fifo.sv
// Self-checking bench for bit_fifo (IWIDTH=3, OWIDTH=7) against a bit-queue reference model.
module tb_bit_fifo;

  localparam int IW = 3;
  localparam int OW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [IW-1:0] din = '0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic [OW-1:0] out;
  logic          out_valid;

  int errors = 0;
  int checks = 0;

  bit            mq[$];
  logic [OW-1:0] exp_out = '0;
  logic          exp_vld = 1'b0;
  logic [OW-1:0] got[$];

  always #5 clk = ~clk;

  bit_fifo #(.IWIDTH(IW), .OWIDTH(OW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .in(din),
    .in_valid(in_valid),
`ifdef BIT_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .out(out),
    .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_out = '0;
    exp_vld = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input logic e, input logic v, input logic [IW-1:0] d, input logic f);
    en = e; in_valid = v; din = d; flush = f;
    @(posedge clk);
    if (e && v)
      for (int b = IW - 1; b >= 0; b--) mq.push_back(d[b]);
    exp_vld = 1'b0;
    if (mq.size() >= OW) begin
      for (int b = OW - 1; b >= 0; b--) exp_out[b] = mq.pop_front();
      exp_vld = 1'b1;
    end
`ifdef BIT_FIFO_FLUSH_EN
    else if (f && mq.size() > 0) begin
      exp_out = '0;
      for (int b = OW - 1; b >= 0 && mq.size() > 0; b--) exp_out[b] = mq.pop_front();
      exp_vld = 1'b1;
    end
`endif
    #1;
    chk("out_valid", OW'(out_valid), OW'(exp_vld));
    chk("out", out, exp_out);
    if (out_valid === 1'b1) got.push_back(out);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0; in_valid = 1'b0; flush = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", OW'(out_valid), '0);
    chk("rst_out", out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
  endtask

  task automatic chk_got(input string tag, input int n, input logic [OW-1:0] e0,
                         input logic [OW-1:0] e1, input logic [OW-1:0] e2, input logic [OW-1:0] e3);
    logic [OW-1:0] ev[4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    chk({tag, "_count"}, OW'(got.size()), OW'(n));
    for (int i = 0; i < n && i < got.size(); i++) chk(tag, got[i], ev[i]);
  endtask

  initial begin
    // Reset and idle
    #12;
    chk("reset_out_valid", OW'(out_valid), '0);
    chk("reset_out", out, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, '0, 1'b0);
    chk_got("idle", 0, '0, '0, '0, '0);

    // Invalid data ignored, then three valid words are needed
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 3'b101, 1'b0);
    cyc(1'b1, 1'b1, 3'b101, 1'b0);
    cyc(1'b1, 1'b1, 3'b101, 1'b0);
    chk("invalid_no_early", OW'(got.size()), '0);
    cyc(1'b1, 1'b1, 3'b101, 1'b0);
    chk_got("invalid_then_valid", 1, 7'h5B, '0, '0, '0);

    // Streaming: pulses after accepts 3, 5, 7, 10
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 1'b1, 3'b101, 1'b0);
      chk("stream_pulse", OW'(out_valid), OW'(i == 3 || i == 5 || i == 7 || i == 10));
    end
    chk_got("stream", 4, 7'h5B, 7'h36, 7'h6D, 7'h5B);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 3'b101, 1'b0);
    chk_got("stream_drain", 4, 7'h5B, 7'h36, 7'h6D, 7'h5B);

    // Enable gating
    do_reset();
    for (int i = 0; i < 14; i++) cyc(1'(i % 2 == 0), 1'b1, 3'b101, 1'b0);
    chk_got("en_gate", 3, 7'h5B, 7'h36, 7'h6D, '0);

    // Asynchronous reset between edges, mid-stream
    do_reset();
    cyc(1'b1, 1'b1, 3'b111, 1'b0);
    cyc(1'b1, 1'b1, 3'b111, 1'b0);
    cyc(1'b1, 1'b1, 3'b111, 1'b0);
    cyc(1'b1, 1'b1, 3'b011, 1'b0);
    cyc(1'b1, 1'b1, 3'b010, 1'b0);
    en = 1'b0; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_out_valid", OW'(out_valid), '0);
    chk("async_rst_out", out, '0);
    #1 rst_n = 1'b1;
    got.delete();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 3'b101, 1'b0);
    chk_got("after_async_rst", 1, 7'h5B, '0, '0, '0);

`ifdef BIT_FIFO_FLUSH_EN
    // Flush of a single held word
    do_reset();
    cyc(1'b1, 1'b1, 3'b101, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("flush_out", out, 7'b1010000);
    chk("flush_valid", OW'(out_valid), OW'(1));
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("flush_empty", OW'(out_valid), '0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
          IW'($urandom), 1'($urandom_range(0, 7) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
